// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - command/status bundle between round logic and the countdown timer
`timescale 1ns/1ps
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] value;
    logic             running;
    logic             done;
    logic             expired;

    modport master (
        output load, load_value, start, pause,
        input  value, running, done, expired
    );

    modport slave (
        input  load, load_value, start, pause,
        output value, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable, pausable, saturating down-counter with prescaled tick
`timescale 1ns/1ps
module countdown_timer #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int TICK_DIV = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    countdown_timer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] L_MAX       = WIDTH'(MAX);
    localparam logic [PW-1:0]    L_TICK_LAST = PW'(TICK_DIV - 1);

    logic [1:0]       r_state, w_next_state;
    logic [WIDTH-1:0] r_value, w_next_value;
    logic [PW-1:0]    r_presc, w_next_presc;
    logic             w_next_done;
    logic             r_done, r_running, r_expired;

    always_comb begin
        w_next_state = r_state;
        w_next_value = r_value;
        w_next_presc = r_presc;
        w_next_done  = 1'b0;
        if (bus.load) begin
            w_next_value = (bus.load_value > L_MAX) ? L_MAX : bus.load_value;
            w_next_presc = '0;
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // pause in IDLE does nothing except mask a simultaneous start
                    if (bus.start && !bus.pause) begin
                        if (r_value != '0) begin
                            w_next_state = S_RUN;
                            w_next_presc = '0;
                        end else begin
                            w_next_state = S_DONE;
                            w_next_done  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        w_next_state = S_PAUSE;
                    end else if (r_presc == L_TICK_LAST) begin
                        w_next_presc = '0;
                        w_next_value = r_value - 1'b1;
                        if (r_value == WIDTH'(1)) begin
                            w_next_state = S_DONE;
                            w_next_done  = 1'b1;
                        end
                    end else begin
                        w_next_presc = r_presc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (bus.start && !bus.pause)
                        w_next_state = S_RUN;
                end
                default: begin
                    w_next_state = S_DONE;
                end
            endcase
        end
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_value   <= L_MAX;
            r_presc   <= '0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_value   <= w_next_value;
            r_presc   <= w_next_presc;
            r_done    <= w_next_done;
            r_running <= (w_next_state == S_RUN);
            r_expired <= (w_next_state == S_DONE);
        end
    end

    assign bus.value   = r_value;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.expired = r_expired;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed checks of countdown_timer against a reference model
`timescale 1ns/1ps
module tb_countdown_timer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(4)) if_a ();
    countdown_timer_if #(.WIDTH(5)) if_b ();
    countdown_timer_if #(.WIDTH(4)) if_c ();

    countdown_timer #(.WIDTH(4), .MAX(15), .TICK_DIV(1)) dut_a (.i_clk(clk), .i_reset(reset), .bus(if_a.slave));
    countdown_timer #(.WIDTH(5), .MAX(15), .TICK_DIV(1)) dut_b (.i_clk(clk), .i_reset(reset), .bus(if_b.slave));
    countdown_timer #(.WIDTH(4), .MAX(15), .TICK_DIV(4)) dut_c (.i_clk(clk), .i_reset(reset), .bus(if_c.slave));

    int checks   = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_state [3];
    int m_val   [3];
    int m_presc [3];
    int m_done  [3];
    int tdiv    [3] = '{1, 1, 4};
    int lv_mask [3] = '{15, 31, 15};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = M_IDLE;
            m_val[k]   = 15;
            m_presc[k] = 0;
            m_done[k]  = 0;
        end
    endtask

    task automatic model_step(input int k, input bit l, input int lv, input bit s, input bit p);
        int v;
        m_done[k] = 0;
        if (l) begin
            v          = lv & lv_mask[k];
            m_val[k]   = (v > 15) ? 15 : v;
            m_presc[k] = 0;
            m_state[k] = M_IDLE;
        end else if (m_state[k] == M_IDLE) begin
            if (s && !p) begin
                if (m_val[k] != 0) begin
                    m_state[k] = M_RUN;
                    m_presc[k] = 0;
                end else begin
                    m_state[k] = M_DONE;
                    m_done[k]  = 1;
                end
            end
        end else if (m_state[k] == M_RUN) begin
            if (p) m_state[k] = M_PAUSE;
            else if (m_presc[k] == tdiv[k] - 1) begin
                m_presc[k] = 0;
                m_val[k]   = m_val[k] - 1;
                if (m_val[k] == 0) begin
                    m_state[k] = M_DONE;
                    m_done[k]  = 1;
                end
            end else m_presc[k] = m_presc[k] + 1;
        end else if (m_state[k] == M_PAUSE) begin
            if (s && !p) m_state[k] = M_RUN;
        end
    endtask

    task automatic check_inst(input string name, input int k, input logic [31:0] v,
                              input logic r, input logic d, input logic e);
        check_eq({name, ".value"},   v, m_val[k]);
        check_eq({name, ".running"}, {31'd0, r}, (m_state[k] == M_RUN)  ? 1 : 0);
        check_eq({name, ".done"},    {31'd0, d}, m_done[k]);
        check_eq({name, ".expired"}, {31'd0, e}, (m_state[k] == M_DONE) ? 1 : 0);
    endtask

    task automatic check_all();
        check_inst("a", 0, {28'd0, if_a.value}, if_a.running, if_a.done, if_a.expired);
        check_inst("b", 1, {27'd0, if_b.value}, if_b.running, if_b.done, if_b.expired);
        check_inst("c", 2, {28'd0, if_c.value}, if_c.running, if_c.done, if_c.expired);
    endtask

    task automatic drive(input bit l, input logic [4:0] lv, input bit s, input bit p);
        if_a.load = l; if_a.load_value = lv[3:0]; if_a.start = s; if_a.pause = p;
        if_b.load = l; if_b.load_value = lv;      if_b.start = s; if_b.pause = p;
        if_c.load = l; if_c.load_value = lv[3:0]; if_c.start = s; if_c.pause = p;
    endtask

    task automatic step(input bit l, input logic [4:0] lv, input bit s, input bit p);
        drive(l, lv, s, p);
        @(negedge clk);
        for (int k = 0; k < 3; k++) model_step(k, l, int'(lv), s, p);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 5'd0, 0, 0);
        model_reset();
        #2 reset = 1'b1;
        #1;
        check_all();
        check_eq("reset.value", {28'd0, if_a.value}, 15);
        @(posedge clk);
        #1 reset = 1'b0;

        // load 5, start, count to zero then stay expired
        step(1, 5'd5, 0, 0);
        step(0, 5'd0, 1, 0);
        check_eq("t2.running", {31'd0, if_a.running}, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 5'd0, 0, 0);
            check_eq("t2.value", {28'd0, if_a.value}, 4 - i);
            check_eq("t2.done", {31'd0, if_a.done}, (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 5'd0, i[0], i[1]);
            check_eq("t2.expired", {31'd0, if_a.expired}, 1);
            check_eq("t2.done_low", {31'd0, if_a.done}, 0);
        end

        // pause at 3 for 10 edges then resume
        step(1, 5'd8, 0, 0);
        step(0, 5'd0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 5'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 5'd0, 0, 1);
            check_eq("t3.hold", {28'd0, if_a.value}, 3);
            check_eq("t3.paused", {31'd0, if_a.running}, 0);
        end
        step(0, 5'd0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 5'd0, 0, 0);
        check_eq("t3.zero", {28'd0, if_a.value}, 0);
        check_eq("t3.done", {31'd0, if_a.done}, 1);

        // clamp, zero start, reload from DONE
        step(1, 5'd20, 0, 0);
        check_eq("t4.clamp", {27'd0, if_b.value}, 15);
        step(1, 5'd0, 0, 0);
        step(0, 5'd0, 1, 0);
        check_eq("t4.done", {31'd0, if_b.done}, 1);
        check_eq("t4.expired", {31'd0, if_b.expired}, 1);
        step(0, 5'd0, 0, 0);
        check_eq("t4.done_once", {31'd0, if_b.done}, 0);
        step(1, 5'd7, 0, 0);
        check_eq("t4.reload", {27'd0, if_b.value}, 7);
        check_eq("t4.unexpired", {31'd0, if_b.expired}, 0);

        // prescaled countdown on dut_c
        step(1, 5'd2, 0, 0);
        step(0, 5'd0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 5'd0, 0, 0);
            check_eq("t5.value", {28'd0, if_c.value}, (i < 4) ? 2 : (i < 8) ? 1 : 0);
            check_eq("t5.done", {31'd0, if_c.done}, (i == 8) ? 1 : 0);
        end

        // asynchronous reset mid-run
        step(1, 5'd10, 0, 0);
        step(0, 5'd0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 5'd0, 0, 0);
        check_eq("t6.pre", {28'd0, if_a.value}, 6);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("t6.value", {28'd0, if_a.value}, 15);
        check_eq("t6.running", {31'd0, if_a.running}, 0);
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 5'd9, 0, 0);
        step(0, 5'd0, 1, 0);
        step(0, 5'd0, 1, 1);
        check_eq("t6.pause_wins", {31'd0, if_a.running}, 0);
        check_eq("t6.pause_hold", {28'd0, if_a.value}, 9);

        for (int n = 0; n < 800; n++) begin
            bit l, s, p;
            logic [4:0] lv;
            l  = ($urandom_range(0, 99) < 6);
            s  = ($urandom_range(0, 99) < 25);
            p  = ($urandom_range(0, 99) < 10);
            lv = 5'($urandom_range(0, 31));
            step(l, lv, s, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
